mt9v032_skew_ctrl: RTL and testbench
====================================

// Module: mt9v032_skew_ctrl
// PURPOSE
//  Initiator side of the sensor-clock skew handshake (skew_en/skew_inc/skew_ack) on the clk_9x domain.
//  Integrates early/late phase votes from the LVDS data receiver's edge detector. Once a vote
//  threshold is reached, it requests a one-step (1/36 pixel-clock) rotation of the output clock pattern.
//  Tracks the net skew position modulo the pattern length and reports lock.
// PARAMETERS
//  THRESH       64    |accumulator| at which one skew step is requested (1..2^(ACC_BITS-1)-1)
//  ACC_BITS     8     signed vote-accumulator width
//  HOLDOFF      16    clk_9x cycles after a completed step during which votes are discarded
//  LOCK_CYCLES  4096  step-free enabled cycles required to assert locked
//  PATTERN_LEN  36    clock-pattern length in bits; skew_pos wraps modulo this value
// PORTS
//  clk_9x       in   1   block clock (pixel clock * 9)
//  rst_9x       in   1   asynchronous, active-high reset
//  enable       in   1   1 = tracking active; 0 = votes ignored, accumulator cleared
//  phase_valid  in   1   qualifies phase_early/phase_late this cycle
//  phase_early  in   1   vote: increase clock delay
//  phase_late   in   1   vote: decrease clock delay
//  skew_en      out  1   step request, held until skew_ack=1
//  skew_inc     out  1   step direction (1 = increase clock delay); stable while skew_en=1
//  skew_ack     in   1   responder acknowledge
//  skew_pos     out  6   net skew position, 0..PATTERN_LEN-1
//  locked       out  1   no step requested for LOCK_CYCLES enabled cycles
// BEHAVIOUR
//  Reset values: skew_en=0, skew_inc=0, skew_pos=0, locked=0, acc=0, lock_cnt=0, state=IDLE.
//  Vote, IDLE state only, enable=1, phase_valid=1:
//   - early&!late: acc+1; late&!early: acc-1; both or neither: acc unchanged.
//   - acc saturates at +/-(2^(ACC_BITS-1)-1); it never wraps.
//  State IDLE:
//   - enable=0: acc<=0, lock_cnt<=0, locked<=0.
//   - acc (after this cycle's update) >= +THRESH: next cycle skew_en=1, skew_inc=1, go to REQ.
//   - acc <= -THRESH: next cycle skew_en=1, skew_inc=0, go to REQ.
//   - Request issue clears acc, lock_cnt and locked in the same edge.
//   - Otherwise, with enable=1: lock_cnt increments, saturating at LOCK_CYCLES; locked<=1 when lock_cnt reaches LOCK_CYCLES.
//  State REQ:
//   - Hold skew_en=1 and skew_inc; ignore votes.
//   - On the first cycle with skew_ack=1: skew_en<=0; skew_pos<=skew_pos+1 (inc) or -1 (dec), wrapping 35->0 and 0->35; go to RELEASE.
//   - No timeout; the request persists indefinitely.
//  State RELEASE:
//   - Wait for skew_ack=0, then load the holdoff counter with HOLDOFF and go to HOLDOFF.
//   - skew_en is never reasserted while skew_ack=1.
//  State HOLDOFF:
//   - Decrement the counter; votes discarded; acc held at 0.
//   - Go to IDLE on the cycle the counter reaches 0, i.e. exactly HOLDOFF cycles spent in HOLDOFF.
//  Minimum request spacing: the responder acks 1 cycle after skew_en rises and drops ack 1 cycle after skew_en falls.
//   Spacing = REQ(1) + RELEASE(1) + HOLDOFF + re-accumulation.
//  enable falling in REQ/RELEASE/HOLDOFF: the handshake and skew_pos update still complete (the responder may
//   already have rotated); enable is sampled again on return to IDLE.
//  skew_inc changes only in the same edge that raises skew_en.
//  rst_9x mid-operation: all state returns to reset values immediately. The responder shares rst_9x, so skew_pos=0
//   matches its reset pattern.
//  All outputs are registered; there are no combinational paths from inputs to outputs.
// TESTING
//  1 Reset: assert rst_9x mid-REQ -> skew_en=0, skew_pos=0, locked=0 asynchronously; IDLE after release.
//  2 Increase step: 64 valid early votes, responder acks 1 cycle later.
//    -> skew_en rises 1 cycle after the 64th vote with skew_inc=1; skew_pos=1; no new request for >=18 cycles.
//  3 Wrap: from skew_pos=0, drive 64 late votes -> skew_inc=0, skew_pos=35; then 64 early votes -> skew_pos=0.
//  4 Cancellation: 200 cycles with early=late=1 plus alternating single votes -> acc stays within +/-1, no skew_en.
//  5 Holdoff/ack stall: hold skew_ack low 50 cycles -> skew_en stays 1 with stable skew_inc.
//    Votes driven during REQ/RELEASE/HOLDOFF do not count toward the next request.
//  6 Lock/enable: 4096 enabled vote-free cycles -> locked=1. Drop enable during REQ -> handshake completes, skew_pos
//    updates, acc=0 and locked=0 in IDLE.

Source files
------------

// File: rtl/mt9v032_skew_ctrl_if.sv
// Sensor-clock skew handshake between the vote integrator (master) and the
// clock-pattern rotator (slave).
interface mt9v032_skew_ctrl_if;
    logic skew_en;
    logic skew_inc;
    logic skew_ack;

    modport master (output skew_en, output skew_inc, input skew_ack);
    modport slave  (input skew_en, input skew_inc, output skew_ack);
endinterface

// File: rtl/mt9v032_skew_ctrl.sv
// Integrates early/late phase votes on clk_9x and requests single-step rotations
// of the sensor clock pattern, tracking the net skew position and lock.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | integrating votes, counting step-free cycles toward lock
// S_REQ     | skew_en held high with fixed direction, waiting for skew_ack
// S_RELEASE | step taken, waiting for the responder to drop skew_ack
// S_HOLDOFF | votes discarded for HOLDOFF cycles while the new phase settles
module mt9v032_skew_ctrl #(
    parameter int THRESH      = 64,
    parameter int ACC_BITS    = 8,
    parameter int HOLDOFF     = 16,
    parameter int LOCK_CYCLES = 4096,
    parameter int PATTERN_LEN = 36
) (
    input  logic                       clk_9x,
    input  logic                       rst_9x,
    input  logic                       enable,
    input  logic                       phase_valid,
    input  logic                       phase_early,
    input  logic                       phase_late,
    mt9v032_skew_ctrl_if.master        skew,
    output logic [5:0]                 skew_pos,
    output logic                       locked
);

    localparam int LOCK_W = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
    localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    localparam logic signed [ACC_BITS-1:0] ACC_HI  = ACC_BITS'(2 ** (ACC_BITS - 1) - 1);
    localparam logic signed [ACC_BITS-1:0] ACC_LO  = -ACC_HI;
    localparam logic signed [ACC_BITS-1:0] ACC_ONE = ACC_BITS'(1);
    localparam logic signed [ACC_BITS-1:0] THR_P   = ACC_BITS'(THRESH);
    localparam logic signed [ACC_BITS-1:0] THR_N   = -THR_P;
    localparam logic [LOCK_W-1:0]          LOCK_MAX = LOCK_W'(LOCK_CYCLES);
    localparam logic [HOLD_W-1:0]          HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [5:0]                 POS_LAST = 6'(PATTERN_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RELEASE,
        S_HOLDOFF
    } state_t;

    state_t                      state;
    logic signed [ACC_BITS-1:0]  acc;
    logic signed [ACC_BITS-1:0]  acc_next;
    logic [LOCK_W-1:0]           lock_cnt;
    logic [LOCK_W-1:0]           lock_inc;
    logic [HOLD_W-1:0]           hold_cnt;
    logic [5:0]                  pos_up;
    logic [5:0]                  pos_dn;

    // Saturating vote integration; only consumed while in S_IDLE.
    always_comb begin
        acc_next = acc;
        if (enable && phase_valid) begin
            if (phase_early && !phase_late && (acc != ACC_HI)) begin
                acc_next = acc + ACC_ONE;
            end else if (phase_late && !phase_early && (acc != ACC_LO)) begin
                acc_next = acc - ACC_ONE;
            end
        end
    end

    always_comb begin
        lock_inc = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LOCK_W'(1);
        pos_up   = (skew_pos == POS_LAST) ? 6'd0 : skew_pos + 6'd1;
        pos_dn   = (skew_pos == 6'd0) ? POS_LAST : skew_pos - 6'd1;
    end

    always_ff @(posedge clk_9x or posedge rst_9x) begin
        if (rst_9x) begin
            state         <= S_IDLE;
            acc           <= '0;
            lock_cnt      <= '0;
            hold_cnt      <= '0;
            locked        <= 1'b0;
            skew_pos      <= 6'd0;
            skew.skew_en  <= 1'b0;
            skew.skew_inc <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!enable) begin
                        acc      <= '0;
                        lock_cnt <= '0;
                        locked   <= 1'b0;
                    // A stale ack defers the request so skew_en never rises under it.
                    end else if ((acc_next >= THR_P) && !skew.skew_ack) begin
                        skew.skew_en  <= 1'b1;
                        skew.skew_inc <= 1'b1;
                        acc           <= '0;
                        lock_cnt      <= '0;
                        locked        <= 1'b0;
                        state         <= S_REQ;
                    end else if ((acc_next <= THR_N) && !skew.skew_ack) begin
                        skew.skew_en  <= 1'b1;
                        skew.skew_inc <= 1'b0;
                        acc           <= '0;
                        lock_cnt      <= '0;
                        locked        <= 1'b0;
                        state         <= S_REQ;
                    end else begin
                        acc      <= acc_next;
                        lock_cnt <= lock_inc;
                        if (lock_inc == LOCK_MAX) begin
                            locked <= 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    if (skew.skew_ack) begin
                        skew.skew_en <= 1'b0;
                        skew_pos     <= skew.skew_inc ? pos_up : pos_dn;
                        state        <= S_RELEASE;
                    end
                end

                S_RELEASE: begin
                    if (!skew.skew_ack) begin
                        if (HOLDOFF == 0) begin
                            state <= S_IDLE;
                        end else begin
                            hold_cnt <= HOLD_LOAD;
                            state    <= S_HOLDOFF;
                        end
                    end
                end

                S_HOLDOFF: begin
                    acc      <= '0;
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                    if (hold_cnt <= HOLD_W'(1)) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mt9v032_skew_ctrl.sv
// Directed bench for mt9v032_skew_ctrl: vector table for the basic step flow,
// hand sequences for reset, wrap, cancellation, ack stall and lock/enable.
module tb_mt9v032_skew_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       phase_valid = 1'b0;
    logic       phase_early = 1'b0;
    logic       phase_late = 1'b0;
    logic [5:0] skew_pos;
    logic       locked;

    mt9v032_skew_ctrl_if bus ();

    mt9v032_skew_ctrl dut (
        .clk_9x      (clk),
        .rst_9x      (rst),
        .enable      (enable),
        .phase_valid (phase_valid),
        .phase_early (phase_early),
        .phase_late  (phase_late),
        .skew        (bus),
        .skew_pos    (skew_pos),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en;
        logic valid;
        logic early;
        logic late;
        int   n;
        logic exp_en;
        logic exp_inc;
        int   exp_pos;
        logic exp_locked;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    int n_checks = 0;
    int n_fail   = 0;
    bit ack_auto = 1'b1;
    bit prev_en  = 1'b0;
    bit prev_inc = 1'b0;
    bit prev_ack = 1'b0;
    int inc_glitch   = 0;
    int en_under_ack = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n cycles; the responder (when automatic) mirrors skew_en onto skew_ack.
    task automatic cyc(input int n);
        repeat (n) begin
            prev_ack = bus.skew_ack;
            @(posedge clk);
            #1;
            if (prev_en && bus.skew_en && (bus.skew_inc !== prev_inc)) inc_glitch++;
            if (!prev_en && bus.skew_en && prev_ack) en_under_ack++;
            prev_en  = bus.skew_en;
            prev_inc = bus.skew_inc;
            if (ack_auto) bus.skew_ack = bus.skew_en;
        end
    endtask

    task automatic vote(input bit v, input bit e, input bit l, input int n);
        phase_valid = v;
        phase_early = e;
        phase_late  = l;
        cyc(n);
    endtask

    task automatic do_step(input bit up, input int exp_pos, input string nm);
        vote(1'b1, up, !up, 64);
        check({nm, "_en"}, bus.skew_en, 1);
        check({nm, "_inc"}, bus.skew_inc, up);
        vote(1'b0, 1'b0, 1'b0, 1);
        check({nm, "_en_drop"}, bus.skew_en, 0);
        check({nm, "_pos"}, skew_pos, exp_pos);
        vote(1'b0, 1'b0, 1'b0, 17);
        check({nm, "_quiet"}, bus.skew_en, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        bit saw;

        //          en valid early late  n  | en inc pos locked
        vt[0]  = '{1, 1, 1, 0, 63,  0, 0, 0, 0};
        vt[1]  = '{1, 1, 1, 0, 1,   1, 1, 0, 0};
        vt[2]  = '{1, 0, 0, 0, 1,   0, 1, 1, 0};
        vt[3]  = '{1, 0, 0, 0, 1,   0, 1, 1, 0};
        vt[4]  = '{1, 1, 1, 0, 16,  0, 1, 1, 0};
        vt[5]  = '{1, 1, 1, 0, 63,  0, 1, 1, 0};
        vt[6]  = '{1, 1, 1, 0, 1,   1, 1, 1, 0};
        vt[7]  = '{1, 0, 0, 0, 1,   0, 1, 2, 0};
        vt[8]  = '{1, 0, 0, 0, 18,  0, 1, 2, 0};
        vt[9]  = '{1, 1, 0, 1, 63,  0, 1, 2, 0};
        vt[10] = '{1, 1, 0, 1, 1,   1, 0, 2, 0};
        vt[11] = '{1, 0, 0, 0, 1,   0, 0, 1, 0};
        vt[12] = '{0, 1, 1, 0, 20,  0, 0, 1, 0};
        vt[13] = '{1, 1, 1, 0, 63,  0, 0, 1, 0};
        vt[14] = '{1, 1, 1, 0, 1,   1, 1, 1, 0};
        vt[15] = '{1, 0, 0, 0, 1,   0, 1, 2, 0};
        vt[16] = '{1, 0, 0, 0, 18,  0, 1, 2, 0};

        bus.skew_ack = 1'b0;
        cyc(2);
        check("reset_en", bus.skew_en, 0);
        check("reset_inc", bus.skew_inc, 0);
        check("reset_pos", skew_pos, 0);
        check("reset_locked", locked, 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            enable      = vt[i].en;
            phase_valid = vt[i].valid;
            phase_early = vt[i].early;
            phase_late  = vt[i].late;
            cyc(vt[i].n);
            check($sformatf("vec%0d_en", i), bus.skew_en, vt[i].exp_en);
            check($sformatf("vec%0d_inc", i), bus.skew_inc, vt[i].exp_inc);
            check($sformatf("vec%0d_pos", i), skew_pos, vt[i].exp_pos);
            check($sformatf("vec%0d_locked", i), locked, vt[i].exp_locked);
        end

        // Asynchronous reset in the middle of a pending request.
        ack_auto = 1'b0;
        bus.skew_ack = 1'b0;
        vote(1'b1, 1'b1, 1'b0, 64);
        check("prerst_en", bus.skew_en, 1);
        check("prerst_pos", skew_pos, 2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_en", bus.skew_en, 0);
        check("async_rst_inc", bus.skew_inc, 0);
        check("async_rst_pos", skew_pos, 0);
        check("async_rst_locked", locked, 0);
        cyc(2);
        rst = 1'b0;
        ack_auto = 1'b1;
        vote(1'b0, 1'b0, 1'b0, 3);
        check("postrst_idle_en", bus.skew_en, 0);
        check("postrst_pos", skew_pos, 0);

        // Wrap in both directions.
        do_step(1'b0, 35, "wrap_dec");
        do_step(1'b1, 0, "wrap_inc");

        // Cancellation: both-set votes and alternating single votes.
        saw = 1'b0;
        for (int i = 0; i < 200; i++) begin
            phase_valid = 1'b1;
            phase_early = (i % 4) != 3;
            phase_late  = (i % 4) != 1;
            cyc(1);
            if (bus.skew_en) saw = 1'b1;
        end
        check("cancel_no_req", saw, 0);
        vote(1'b1, 1'b1, 1'b0, 63);
        check("cancel_acc63_en", bus.skew_en, 0);
        vote(1'b1, 1'b1, 1'b0, 1);
        check("cancel_acc64_en", bus.skew_en, 1);
        vote(1'b0, 1'b0, 1'b0, 1);
        check("cancel_pos", skew_pos, 1);
        vote(1'b0, 1'b0, 1'b0, 17);

        // Ack stall with votes that must not carry into the next request.
        ack_auto = 1'b0;
        vote(1'b1, 1'b0, 1'b1, 64);
        check("stall_en", bus.skew_en, 1);
        check("stall_inc", bus.skew_inc, 0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            vote(1'b1, 1'b1, 1'b0, 1);
            if (bus.skew_en !== 1'b1 || bus.skew_inc !== 1'b0) bad++;
        end
        check("stall_hold", bad, 0);
        bus.skew_ack = 1'b1;
        ack_auto = 1'b1;
        vote(1'b1, 1'b1, 1'b0, 1);
        check("stall_ack_en", bus.skew_en, 0);
        check("stall_ack_pos", skew_pos, 0);
        vote(1'b1, 1'b1, 1'b0, 17);
        vote(1'b1, 1'b1, 1'b0, 63);
        check("stall_votes_discarded", bus.skew_en, 0);
        vote(1'b1, 1'b1, 1'b0, 1);
        check("stall_next_req", bus.skew_en, 1);
        vote(1'b0, 1'b0, 1'b0, 1);
        check("stall_next_pos", skew_pos, 1);
        vote(1'b0, 1'b0, 1'b0, 17);

        // Lock after LOCK_CYCLES step-free enabled cycles.
        enable = 1'b0;
        cyc(2);
        check("lock_disabled", locked, 0);
        enable = 1'b1;
        cyc(4095);
        check("lock_4095", locked, 0);
        cyc(1);
        check("lock_4096", locked, 1);
        cyc(10);
        check("lock_hold", locked, 1);

        // Enable dropped during a request: handshake still completes.
        ack_auto = 1'b0;
        vote(1'b1, 1'b1, 1'b0, 64);
        check("en_drop_req", bus.skew_en, 1);
        check("en_drop_unlock", locked, 0);
        enable = 1'b0;
        vote(1'b0, 1'b0, 1'b0, 3);
        check("en_drop_still_req", bus.skew_en, 1);
        bus.skew_ack = 1'b1;
        ack_auto = 1'b1;
        cyc(1);
        check("en_drop_ack_en", bus.skew_en, 0);
        check("en_drop_pos", skew_pos, 2);
        cyc(17);
        vote(1'b1, 1'b1, 1'b0, 5);
        check("en_drop_idle_en", bus.skew_en, 0);
        check("en_drop_idle_locked", locked, 0);
        enable = 1'b1;
        vote(1'b1, 1'b1, 1'b0, 63);
        check("reen_acc63", bus.skew_en, 0);
        vote(1'b1, 1'b1, 1'b0, 1);
        check("reen_acc64", bus.skew_en, 1);
        check("reen_inc", bus.skew_inc, 1);
        vote(1'b0, 1'b0, 1'b0, 1);
        check("reen_pos", skew_pos, 3);
        cyc(17);

        check("inc_stable_while_en", inc_glitch, 0);
        check("no_en_under_ack", en_under_ack, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
